// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lamp_pkg
// Description : Shared types and constants for the multi-approach lamp
//               controller: phase encoding, lamp field codes and a helper
//               that sizes the phase timer.
// Revision    : 1.0 - initial release
// ============================================================================
package lamp_pkg;

    // Phase encoding as presented on the phase output.
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_CLEAR  = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    // Per-approach lamp field, ordered {red, green, yellow}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    function automatic int f_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Width able to hold max_len-1; never below one bit so that a design
    // with all durations equal to 1 still has a legal timer vector.
    function automatic int f_timer_width(input int max_len);
        int w;
        w = $clog2(max_len);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : lamp_rr_pick
// Description : Combinational round-robin selector for the next approach to
//               receive green. Searches req starting at active+1 (wrapping)
//               and returns the first requesting index; with no request set
//               it returns active+1 (wrapped).
// Ports       : req      [N_CH-1:0] in  - level service requests
//               active   [AW-1:0]   in  - approach that currently owns green
//               next_idx [AW-1:0]   out - approach chosen for the next green
// Revision    : 1.0 - initial release
// ============================================================================
module lamp_rr_pick
    import lamp_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int AW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [AW-1:0]   active,
    output logic [AW-1:0]   next_idx
);

    always_comb begin : p_pick
        logic [AW-1:0] w_idx;
        logic          w_found;
        w_found  = 1'b0;
        w_idx    = '0;
        next_idx = AW'((int'(active) + 1) % N_CH);
        // Offset N_CH lands back on active itself, so a lone request from
        // the current owner is still honoured as the last candidate.
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = AW'((int'(active) + i) % N_CH);
            if (!w_found && req[w_idx]) begin
                next_idx = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_lamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_lamp_ctrl
// Description : Demand-driven multi-approach traffic-lamp controller. One
//               approach holds green at a time; a hand-over to a requesting
//               approach passes through YELLOW and an all-red CLEAR. Green is
//               extended in GREEN_CYC steps while no other approach requests.
//               Optional maintenance flash mode is compiled in when the macro
//               MULTI_LAMP_FLASH_EN is defined; otherwise flash is ignored.
// Ports       : clock            in  - rising-edge clock
//               reset_n          in  - asynchronous active-low reset
//               req   [N_CH-1:0] in  - level service request per approach
//               flash            in  - maintenance flash request
//               light [3N_CH-1:0] out - {red,green,yellow} field per approach
//               active[AW-1:0]   out - approach owning the green
//               phase [1:0]      out - GREEN=0 YELLOW=1 CLEAR=2 FLASH=3
// Revision    : 1.0 - initial release
// ============================================================================
module multi_lamp_ctrl
    import lamp_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int CLEAR_CYC  = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         req,
    input  logic                    flash,
    output logic [3*N_CH-1:0]       light,
    output logic [$clog2(N_CH)-1:0] active,
    output logic [1:0]              phase
);

    localparam int c_AW = $clog2(N_CH);
    localparam int c_TW = f_timer_width(f_max4(GREEN_CYC, YELLOW_CYC, CLEAR_CYC, FLASH_HALF));

    localparam logic [c_TW-1:0] c_GREEN_LOAD  = c_TW'(GREEN_CYC - 1);
    localparam logic [c_TW-1:0] c_YELLOW_LOAD = c_TW'(YELLOW_CYC - 1);
    localparam logic [c_TW-1:0] c_CLEAR_LOAD  = c_TW'(CLEAR_CYC - 1);

    localparam logic [3*N_CH-1:0] c_ALL_RED = {N_CH{LAMP_RED}};

    phase_t               r_phase;
    logic [c_TW-1:0]      r_timer;
    logic [c_AW-1:0]      r_active;
    logic [3*N_CH-1:0]    r_light;

    logic [c_AW-1:0]      w_next_active;
    logic [N_CH-1:0]      w_own;
    logic                 w_other_req;

`ifdef MULTI_LAMP_FLASH_EN
    localparam logic [c_TW-1:0]   c_FLASH_LOAD  = c_TW'(FLASH_HALF - 1);
    localparam logic [3*N_CH-1:0] c_ALL_YELLOW  = {N_CH{LAMP_YELLOW}};
    localparam logic [3*N_CH-1:0] c_ALL_OFF     = {N_CH{LAMP_OFF}};

    // Low while the yellow half of the blink is showing.
    logic                 r_blink;
`else
    logic                 w_unused_flash;
    assign w_unused_flash = flash;
`endif

    lamp_rr_pick #(
        .N_CH (N_CH),
        .AW   (c_AW)
    ) u_rr_pick (
        .req      (req),
        .active   (r_active),
        .next_idx (w_next_active)
    );

    // A hand-over is only worth doing if someone other than the owner asks.
    assign w_own       = {{(N_CH-1){1'b0}}, 1'b1} << r_active;
    assign w_other_req = |(req & ~w_own);

    // Lamp image for the steady phases; the owner shows the phase colour and
    // every other approach stays red.
    function automatic logic [3*N_CH-1:0] f_lamps(input phase_t ph, input logic [c_AW-1:0] act);
        logic [3*N_CH-1:0] v;
        v = c_ALL_RED;
        for (int c = 0; c < N_CH; c++) begin
            if (c_AW'(c) == act) begin
                if (ph == PH_GREEN)       v[3*c +: 3] = LAMP_GREEN;
                else if (ph == PH_YELLOW) v[3*c +: 3] = LAMP_YELLOW;
            end
        end
        return v;
    endfunction

    // Next lamp image is computed alongside the next phase so that lamps,
    // phase and active all move on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase  <= PH_CLEAR;
            r_timer  <= c_CLEAR_LOAD;
            r_active <= c_AW'(N_CH - 1);
            r_light  <= c_ALL_RED;
`ifdef MULTI_LAMP_FLASH_EN
            r_blink  <= 1'b0;
`endif
        end
`ifdef MULTI_LAMP_FLASH_EN
        else if (flash) begin
            if (r_phase != PH_FLASH) begin
                r_phase <= PH_FLASH;
                r_timer <= c_FLASH_LOAD;
                r_blink <= 1'b0;
                r_light <= c_ALL_YELLOW;
            end else if (r_timer == '0) begin
                r_timer <= c_FLASH_LOAD;
                r_blink <= ~r_blink;
                r_light <= r_blink ? c_ALL_YELLOW : c_ALL_OFF;
            end else begin
                r_timer <= r_timer - 1'b1;
            end
        end
`endif
        else begin
            case (r_phase)
                PH_GREEN: begin
                    if (r_timer == '0) begin
                        if (w_other_req) begin
                            r_phase <= PH_YELLOW;
                            r_timer <= c_YELLOW_LOAD;
                            r_light <= f_lamps(PH_YELLOW, r_active);
                        end else begin
                            r_timer <= c_GREEN_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (r_timer == '0) begin
                        r_phase <= PH_CLEAR;
                        r_timer <= c_CLEAR_LOAD;
                        r_light <= c_ALL_RED;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                PH_CLEAR: begin
                    if (r_timer == '0) begin
                        r_phase  <= PH_GREEN;
                        r_timer  <= c_GREEN_LOAD;
                        r_active <= w_next_active;
                        r_light  <= f_lamps(PH_GREEN, w_next_active);
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    // Leaving FLASH: full clearance, owner kept.
                    r_phase <= PH_CLEAR;
                    r_timer <= c_CLEAR_LOAD;
                    r_light <= c_ALL_RED;
                end
            endcase
        end
    end

    assign light  = r_light;
    assign active = r_active;
    assign phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_multi_lamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_lamp_ctrl
// Description : Self-checking bench for multi_lamp_ctrl at default
//               parameters. Each stimulus step queues the outputs expected
//               after the next rising edge; a monitor pops and compares them.
//               The flash scenario is built when MULTI_LAMP_FLASH_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_lamp_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic        flash;
    logic [11:0] light;
    logic [1:0]  active;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_errors = 0;
    int n_step   = 0;

    typedef struct {
        logic [11:0] l;
        logic [1:0]  a;
        logic [1:0]  p;
    } exp_t;

    exp_t q[$];

`ifdef MULTI_LAMP_FLASH_EN
    localparam bit TOGGLE_FLASH = 1'b0;
`else
    localparam bit TOGGLE_FLASH = 1'b1;
`endif

    always #5 clock = ~clock;

    multi_lamp_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .flash   (flash),
        .light   (light),
        .active  (active),
        .phase   (phase)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All approaches red except ch, which shows code.
    function automatic logic [11:0] lamp1(input int ch, input logic [2:0] code);
        logic [11:0] v;
        v = 12'h924;
        v[3*ch +: 3] = code;
        return v;
    endfunction

    always @(posedge clock) begin : p_monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_val($sformatf("light@%0d", n_step), {20'd0, light}, {20'd0, e.l});
            check_val($sformatf("active@%0d", n_step), {30'd0, active}, {30'd0, e.a});
            check_val($sformatf("phase@%0d", n_step), {30'd0, phase}, {30'd0, e.p});
        end
    end

    // Called at a falling edge: drive inputs, queue what the next rising
    // edge must produce, then advance to the following falling edge.
    task automatic step(input logic [3:0] r, input logic f,
                        input logic [11:0] l, input logic [1:0] a, input logic [1:0] p);
        exp_t e;
        req   = r;
        flash = f;
        e.l = l;
        e.a = a;
        e.p = p;
        q.push_back(e);
        n_step++;
        @(negedge clock);
    endtask

    initial begin
        int         cur;
        logic [3:0] other;

        reset_n = 1'b0;
        req     = 4'b0000;
        flash   = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_light",  {20'd0, light},  32'h924);
        check_val("rst_phase",  {30'd0, phase},  32'd2);
        check_val("rst_active", {30'd0, active}, 32'd3);

        // Release from reset with no requests: two red cycles, then ch0.
        reset_n = 1'b1;
        step(4'b0000, 1'b0, 12'h924, 2'd3, 2'd2);
        repeat (16) step(4'b0000, 1'b0, 12'h922, 2'd0, 2'd0);

        // Hand-over ch0 -> ch2; flash toggles here only when compiled out.
        for (int i = 0; i < 14; i++) begin
            logic f;
            f = TOGGLE_FLASH & i[0];
            if (i == 0)       step(4'b0000, f, 12'h922, 2'd0, 2'd0);
            else if (i < 8)   step(4'b0100, f, 12'h922, 2'd0, 2'd0);
            else if (i < 11)  step(4'b0100, f, 12'h921, 2'd0, 2'd1);
            else if (i < 13)  step(4'b0100, f, 12'h924, 2'd0, 2'd2);
            else              step(4'b0100, f, 12'h8A4, 2'd2, 2'd0);
        end

        // Own request only at ch2: green held past GREEN_CYC.
        repeat (15) step(4'b0100, 1'b0, 12'h8A4, 2'd2, 2'd0);
        repeat (3)  step(4'b1000, 1'b0, 12'h864, 2'd2, 2'd1);
        repeat (2)  step(4'b1000, 1'b0, 12'h924, 2'd2, 2'd2);
        step(4'b1000, 1'b0, 12'h524, 2'd3, 2'd0);

        // Wrap from ch3: ch0 idle, so ch1 is chosen.
        repeat (7) step(4'b0010, 1'b0, 12'h524, 2'd3, 2'd0);
        repeat (3) step(4'b0010, 1'b0, 12'h324, 2'd3, 2'd1);
        repeat (2) step(4'b0010, 1'b0, 12'h924, 2'd3, 2'd2);
        step(4'b0010, 1'b0, 12'h914, 2'd1, 2'd0);

        // Own request at ch1 held, then several requests: ch2 is first after ch1.
        repeat (15) step(4'b0010, 1'b0, 12'h914, 2'd1, 2'd0);
        repeat (3)  step(4'b1101, 1'b0, 12'h90C, 2'd1, 2'd1);
        repeat (2)  step(4'b1101, 1'b0, 12'h924, 2'd1, 2'd2);
        step(4'b1101, 1'b0, 12'h8A4, 2'd2, 2'd0);

`ifdef MULTI_LAMP_FLASH_EN
        // Flash from GREEN: yellow half first, 4/4 blink, then CLEAR and
        // round-robin from ch3 to the requesting ch0.
        repeat (4) step(4'b0001, 1'b1, 12'h249, 2'd2, 2'd3);
        repeat (4) step(4'b0001, 1'b1, 12'h000, 2'd2, 2'd3);
        repeat (4) step(4'b0001, 1'b1, 12'h249, 2'd2, 2'd3);
        repeat (2) step(4'b0001, 1'b0, 12'h924, 2'd2, 2'd2);
        step(4'b0001, 1'b0, 12'h922, 2'd0, 2'd0);
        cur   = 0;
        other = 4'b0010;
`else
        cur   = 2;
        other = 4'b0001;
`endif

        // Reset asserted during YELLOW takes effect without a clock edge.
        repeat (7) step(other, 1'b0, lamp1(cur, 3'b010), 2'(cur), 2'd0);
        step(other, 1'b0, lamp1(cur, 3'b001), 2'(cur), 2'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_light",  {20'd0, light},  32'h924);
        check_val("mid_rst_phase",  {30'd0, phase},  32'd2);
        check_val("mid_rst_active", {30'd0, active}, 32'd3);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        step(4'b0000, 1'b0, 12'h924, 2'd3, 2'd2);
        step(4'b0000, 1'b0, 12'h922, 2'd0, 2'd0);

        check_val("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_lamp_ctrl.md
# multi_lamp_ctrl

Parametrised multi-approach traffic-lamp controller. It drives N_CH one-hot lamp triplets, giving one approach green at a time. Green is demand-driven: the controller moves to another approach only when that approach requests service. Each hand-over passes through yellow and an all-red clearance, and an optional maintenance flash mode can be compiled in. The block sits at the top of the lamp-control path and feeds the lamp drivers directly.

## Interface
- N_CH, 4: number of approaches; N_CH ≥ 2
- GREEN_CYC, 8: minimum green length in cycles; ≥ 1
- YELLOW_CYC, 3: yellow length in cycles; ≥ 1
- CLEAR_CYC, 2: all-red clearance length in cycles; ≥ 1
- FLASH_HALF, 4: half-period of the flash blink in cycles; ≥ 1
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_CH  level service request per approach; the owner deasserts it
- flash  in  1  maintenance flash request; sampled synchronously
- light  out  3*N_CH  field c = light[3c+2:3c], encoded {red,green,yellow}: red 3'b100, green 3'b010, yellow 3'b001
- active  out  $clog2(N_CH)  approach currently owning the green
- phase  out  2  GREEN=0, YELLOW=1, CLEAR=2, FLASH=3

## Operation
- **Reset (async):** phase=CLEAR, timer=CLEAR_CYC-1, active=N_CH-1, every lamp field red. All outputs are registered, and every output takes its reset value immediately, without waiting for a clock edge.
- **GREEN:** field `active` is green and all other fields are red. The timer counts down. When the timer reaches 0:
  - if `req & ~onehot(active)` ≠ 0, go to YELLOW;
  - otherwise reload the timer and stay in GREEN (the green is extended indefinitely).
- **YELLOW:** field `active` is yellow and all other fields are red. Lasts exactly YELLOW_CYC cycles, then CLEAR.
- **CLEAR:** all fields red. Lasts exactly CLEAR_CYC cycles, then GREEN. The new `active` is chosen as follows:
  - round-robin search starting at active+1, wrapping modulo N_CH; take the first set `req` bit;
  - if no bit is set, take active+1 (wrapped).
- `req` is sampled only on decision cycles (GREEN timer==0, and the last CLEAR cycle). It is never latched.
- The timer is $clog2(max(GREEN_CYC,YELLOW_CYC,CLEAR_CYC,FLASH_HALF)) bits wide. It is loaded with duration-1 on every phase entry.

## Timing
- Lamp fields, `phase` and `active` all change on the same clock edge.
- Each phase is entered on the edge after its predecessor's final cycle.
- Durations are exact: GREEN ≥ GREEN_CYC, YELLOW = YELLOW_CYC, CLEAR = CLEAR_CYC.
- `req` changes only take effect at the next decision cycle.
- When `req` is set only for the active approach, GREEN is held.
- Reset asserted mid-phase aborts that phase immediately. The first green after reset release comes CLEAR_CYC cycles later.

## Configuration
- Macro: `MULTI_LAMP_FLASH_EN`.
- **Defined:**
  - `flash`=1 in any phase moves to FLASH on the next edge; an in-progress green or yellow is abandoned.
  - In FLASH, every field alternates between yellow and 3'b000. Each half lasts FLASH_HALF cycles, and the yellow half comes first.
  - `flash`=0 while in FLASH moves to CLEAR, with a full CLEAR_CYC count and `active` unchanged.
- **Undefined:**
  - `flash` is ignored and the FLASH state and its logic are absent.
  - `phase` never reads 3.

## Structure
- Package `lamp_pkg`:
  - phase enum;
  - lamp encodings LAMP_RED, LAMP_GREEN, LAMP_YELLOW and LAMP_OFF.
- Sub-module `lamp_rr_pick`: combinational round-robin next-approach selector. Inputs are `req` and `active`; output is the next index.
- The phase FSM and the timer live in `multi_lamp_ctrl`.

## Test plan
All scenarios use default parameters.
- **Release from reset:** release reset_n with req=0 → light=12'h924 for 2 cycles, then 12'h922 (ch0 green) with active=0, held indefinitely.
- **Hand-over:** while ch0 is green, set req=4'b0100 → 8 green cycles total, then 3 cycles of 12'h921, 2 cycles of 12'h924, then 12'h8A4 with active=2.
- **Wrap and own request:**
  - active=3, req=4'b0010 → next green is ch1 and ch0 is skipped;
  - req=4'b1000 (own request only) → green is held past 8 cycles.
- **Flash (macro defined):** assert flash during GREEN → next edge phase=3, then 12'h249 for 4 cycles and 12'h000 for 4 cycles, repeating. Deassert flash → 2 cycles of 12'h924, then green per round-robin.
- **Reset mid-phase:** assert reset_n low during YELLOW → light=12'h924, phase=2, active=3 immediately, without a clock edge.
- **Flash compiled out (macro undefined):** toggle flash during the hand-over scenario → output sequence identical to the hand-over scenario.
